// File: rtl/kbd_ascii_fifo_pkg.sv
// Shared constants and decoder state type for the keyboard ASCII path.
package kbd_pkg;

  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;

  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_BS    = 8'h08;
  localparam logic [7:0] ASCII_SPACE = 8'h20;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BRK,
    ST_EXT,
    ST_EXT_BRK
  } kbd_state_e;

  function automatic logic is_shift_code(input logic [7:0] code);
    return (code == SC_LSHIFT) || (code == SC_RSHIFT);
  endfunction

endpackage

// File: rtl/kbd_ascii_fifo_scan_to_ascii.sv
// Combinational PS/2 set-2 make code to US-layout ASCII lookup.
module scan_to_ascii
  import kbd_pkg::*;
(
  input  logic [7:0] code,
  input  logic       shift,
  output logic [7:0] ascii,
  output logic       hit
);

  always_comb begin
    ascii = '0;
    hit   = 1'b1;
    case (code)
      8'h1C: ascii = shift ? 8'h41 : 8'h61;
      8'h32: ascii = shift ? 8'h42 : 8'h62;
      8'h21: ascii = shift ? 8'h43 : 8'h63;
      8'h23: ascii = shift ? 8'h44 : 8'h64;
      8'h24: ascii = shift ? 8'h45 : 8'h65;
      8'h2B: ascii = shift ? 8'h46 : 8'h66;
      8'h34: ascii = shift ? 8'h47 : 8'h67;
      8'h33: ascii = shift ? 8'h48 : 8'h68;
      8'h43: ascii = shift ? 8'h49 : 8'h69;
      8'h3B: ascii = shift ? 8'h4A : 8'h6A;
      8'h42: ascii = shift ? 8'h4B : 8'h6B;
      8'h4B: ascii = shift ? 8'h4C : 8'h6C;
      8'h3A: ascii = shift ? 8'h4D : 8'h6D;
      8'h31: ascii = shift ? 8'h4E : 8'h6E;
      8'h44: ascii = shift ? 8'h4F : 8'h6F;
      8'h4D: ascii = shift ? 8'h50 : 8'h70;
      8'h15: ascii = shift ? 8'h51 : 8'h71;
      8'h2D: ascii = shift ? 8'h52 : 8'h72;
      8'h1B: ascii = shift ? 8'h53 : 8'h73;
      8'h2C: ascii = shift ? 8'h54 : 8'h74;
      8'h3C: ascii = shift ? 8'h55 : 8'h75;
      8'h2A: ascii = shift ? 8'h56 : 8'h76;
      8'h1D: ascii = shift ? 8'h57 : 8'h77;
      8'h22: ascii = shift ? 8'h58 : 8'h78;
      8'h35: ascii = shift ? 8'h59 : 8'h79;
      8'h1A: ascii = shift ? 8'h5A : 8'h7A;
      // digit row: shifted glyphs follow the US keycap legends
      8'h45: ascii = shift ? 8'h29 : 8'h30;
      8'h16: ascii = shift ? 8'h21 : 8'h31;
      8'h1E: ascii = shift ? 8'h40 : 8'h32;
      8'h26: ascii = shift ? 8'h23 : 8'h33;
      8'h25: ascii = shift ? 8'h24 : 8'h34;
      8'h2E: ascii = shift ? 8'h25 : 8'h35;
      8'h36: ascii = shift ? 8'h5E : 8'h36;
      8'h3D: ascii = shift ? 8'h26 : 8'h37;
      8'h3E: ascii = shift ? 8'h2A : 8'h38;
      8'h46: ascii = shift ? 8'h28 : 8'h39;
      8'h29: ascii = ASCII_SPACE;
      8'h5A: ascii = ASCII_CR;
      8'h66: ascii = ASCII_BS;
      default: hit = 1'b0;
    endcase
  end

endmodule

// File: rtl/kbd_ascii_fifo.sv
// Scan-code decoder with shift tracking feeding a first-word-fall-through ASCII FIFO.
module kbd_ascii_fifo
  import kbd_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [7:0]    scan_code,
  input  logic          scan_valid,
  input  logic          ascii_ack,
  output logic [7:0]    ASCII,
  output logic          fifo_ready,
  output logic [AW:0]   count,
  output logic          overflow
);

  kbd_state_e state, state_nxt;
  logic       shift, shift_nxt;
  logic       make_evt;

  logic [7:0]    lut_ascii;
  logic          lut_hit;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;

  logic empty, full, push_req, push, pop, drop;

  scan_to_ascii u_lut (
    .code  (scan_code),
    .shift (shift),
    .ascii (lut_ascii),
    .hit   (lut_hit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      shift <= 1'b0;
    end else begin
      state <= state_nxt;
      shift <= shift_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    shift_nxt = shift;
    make_evt  = 1'b0;
    if (scan_valid) begin
      case (state)
        ST_IDLE: begin
          if (scan_code == SC_BREAK)     state_nxt = ST_BRK;
          else if (scan_code == SC_EXT)  state_nxt = ST_EXT;
          else if (is_shift_code(scan_code)) shift_nxt = 1'b1;
          else                           make_evt  = 1'b1;
        end
        ST_BRK: begin
          if (is_shift_code(scan_code)) shift_nxt = 1'b0;
          state_nxt = ST_IDLE;
        end
        ST_EXT:     state_nxt = (scan_code == SC_BREAK) ? ST_EXT_BRK : ST_IDLE;
        ST_EXT_BRK: state_nxt = ST_IDLE;
        default:    state_nxt = ST_IDLE;
      endcase
    end
  end

  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(DEPTH));
  assign pop      = ascii_ack && !empty;
  assign push_req = make_evt && lut_hit;
  // a simultaneous pop frees the slot, so a full FIFO can still accept
  assign push     = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= lut_ascii;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      if (drop) overflow <= 1'b1;
    end
  end

  assign fifo_ready = !empty;
  assign ASCII      = empty ? '0 : mem[rd_ptr];

endmodule

// File: tb/tb_kbd_ascii_fifo.sv
// Randomized and directed bench for kbd_ascii_fifo against a queue-based keyboard model.
module tb_kbd_ascii_fifo;

  localparam int DEPTH = 8;
  localparam int AW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    scan_code = '0;
  logic          scan_valid = 1'b0;
  logic          ascii_ack = 1'b0;
  logic [7:0]    ASCII;
  logic          fifo_ready;
  logic [AW:0]   count;
  logic          overflow;

  int total = 0;
  int bad   = 0;

  kbd_ascii_fifo #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .scan_code  (scan_code),
    .scan_valid (scan_valid),
    .ascii_ack  (ascii_ack),
    .ASCII      (ASCII),
    .fifo_ready (fifo_ready),
    .count      (count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  // reference model: pending-prefix flags, shift level, character queue
  logic [7:0] q[$];
  bit m_shift, m_f0, m_e0, m_ovf;

  logic [7:0] letter_codes [26] = '{8'h1C,8'h32,8'h21,8'h23,8'h24,8'h2B,8'h34,8'h33,8'h43,
                                     8'h3B,8'h42,8'h4B,8'h3A,8'h31,8'h44,8'h4D,8'h15,8'h2D,
                                     8'h1B,8'h2C,8'h3C,8'h2A,8'h1D,8'h22,8'h35,8'h1A};
  logic [7:0] digit_codes [10] = '{8'h45,8'h16,8'h1E,8'h26,8'h25,8'h2E,8'h36,8'h3D,8'h3E,8'h46};
  logic [7:0] digit_syms  [10] = '{8'h29,8'h21,8'h40,8'h23,8'h24,8'h25,8'h5E,8'h26,8'h2A,8'h28};

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit translate(input logic [7:0] c, input bit sh, output logic [7:0] a);
    a = '0;
    for (int i = 0; i < 26; i++)
      if (c == letter_codes[i]) begin a = (sh ? 8'h41 : 8'h61) + 8'(i); return 1'b1; end
    for (int i = 0; i < 10; i++)
      if (c == digit_codes[i]) begin a = sh ? digit_syms[i] : 8'h30 + 8'(i); return 1'b1; end
    if (c == 8'h29) begin a = 8'h20; return 1'b1; end
    if (c == 8'h5A) begin a = 8'h0D; return 1'b1; end
    if (c == 8'h66) begin a = 8'h08; return 1'b1; end
    return 1'b0;
  endfunction

  function automatic bit is_shift(input logic [7:0] c);
    return c == 8'h12 || c == 8'h59;
  endfunction

  task automatic model_reset();
    q.delete();
    m_shift = 0; m_f0 = 0; m_e0 = 0; m_ovf = 0;
  endtask

  task automatic model_step(input bit v, input logic [7:0] c, input bit a);
    bit pop_ok, do_push;
    logic [7:0] ch;
    pop_ok  = a && (q.size() > 0);
    do_push = 0;
    ch      = '0;
    if (v) begin
      if (m_e0) begin
        if (!m_f0 && c == 8'hF0) m_f0 = 1;
        else begin m_e0 = 0; m_f0 = 0; end
      end else if (m_f0) begin
        if (is_shift(c)) m_shift = 0;
        m_f0 = 0;
      end else if (c == 8'hF0) m_f0 = 1;
      else if (c == 8'hE0)     m_e0 = 1;
      else if (is_shift(c))    m_shift = 1;
      else                     do_push = translate(c, m_shift, ch);
    end
    if (do_push && q.size() == DEPTH && !pop_ok) begin
      m_ovf   = 1;
      do_push = 0;
    end
    if (pop_ok)  void'(q.pop_front());
    if (do_push) q.push_back(ch);
  endtask

  task automatic check_all(input string ph);
    check({ph, ".ascii"}, int'(ASCII), (q.size() != 0) ? int'(q[0]) : 0);
    check({ph, ".ready"}, int'(fifo_ready), int'(q.size() != 0));
    check({ph, ".count"}, int'(count), q.size());
    check({ph, ".ovf"},   int'(overflow), int'(m_ovf));
  endtask

  // inputs change 1 time unit after the rising edge, outputs checked then too
  task automatic cycle(input string ph, input bit v, input logic [7:0] c, input bit a);
    scan_valid = v; scan_code = c; ascii_ack = a;
    @(posedge clk);
    model_step(v, c, a);
    #1;
    scan_valid = 0; ascii_ack = 0; scan_code = '0;
    check_all(ph);
  endtask

  task automatic key(input string ph, input logic [7:0] c);
    cycle(ph, 1'b1, c, 1'b0);
  endtask

  task automatic drain(input string ph);
    for (int i = 0; i < DEPTH + 2 && q.size() > 0; i++) cycle(ph, 1'b0, 8'h00, 1'b1);
    check({ph, ".drained"}, q.size(), 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("rst");
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  function automatic logic [7:0] rand_code();
    int r;
    r = $urandom_range(0, 99);
    if (r < 30) return letter_codes[$urandom_range(0, 25)];
    if (r < 45) return digit_codes[$urandom_range(0, 9)];
    if (r < 52) return (r < 48) ? 8'h29 : (r < 50) ? 8'h5A : 8'h66;
    if (r < 62) return 8'hF0;
    if (r < 70) return 8'hE0;
    if (r < 80) return (r < 75) ? 8'h12 : 8'h59;
    return 8'($urandom_range(0, 255));
  endfunction

  initial begin
    model_reset();
    #12;
    check_all("por");
    do_reset();

    // single character and pop
    key("t1", 8'h1C);
    check("t1.a61", int'(ASCII), 8'h61);
    cycle("t1pop", 1'b0, 8'h00, 1'b1);
    check("t1.empty", int'(ASCII), 0);

    // shift make/break
    key("t2", 8'h12); key("t2", 8'h1C); key("t2", 8'hF0); key("t2", 8'h1C);
    key("t2", 8'hF0); key("t2", 8'h12); key("t2", 8'h1C);
    check("t2.cnt", int'(count), 2);
    check("t2.head", int'(ASCII), 8'h41);
    cycle("t2pop", 1'b0, 8'h00, 1'b1);
    check("t2.next", int'(ASCII), 8'h61);
    drain("t2");

    // extended and unmapped codes
    key("t3", 8'hE0); key("t3", 8'h75); key("t3", 8'hE0); key("t3", 8'hF0);
    key("t3", 8'h75); key("t3", 8'h05);
    check("t3.cnt", int'(count), 0);
    check("t3.ovf", int'(overflow), 0);

    // overflow and wrap
    for (int i = 0; i < DEPTH + 1; i++) key("t4", letter_codes[i]);
    check("t4.full", int'(count), DEPTH);
    check("t4.ovf", int'(overflow), 1);
    drain("t4");

    // push and pop together at full
    for (int i = 0; i < DEPTH; i++) key("t5", digit_codes[(i + 2) % 10]);
    cycle("t5both", 1'b1, 8'h16, 1'b1);
    check("t5.cnt", int'(count), DEPTH);
    for (int i = 0; i < DEPTH - 1; i++) cycle("t5d", 1'b0, 8'h00, 1'b1);
    check("t5.last", int'(ASCII), 8'h31);
    drain("t5");

    // push and ack together when empty
    cycle("t6", 1'b1, 8'h29, 1'b1);
    check("t6.cnt", int'(count), 1);
    drain("t6");

    // reset mid-burst with a break prefix pending
    do_reset();
    key("t7", 8'h1C); key("t7", 8'h32); key("t7", 8'h21); key("t7", 8'hF0);
    do_reset();
    key("t7r", 8'h1C);
    check("t7.a61", int'(ASCII), 8'h61);
    drain("t7");

    // random traffic
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      bit v, a;
      v = ($urandom_range(0, 99) < 65);
      a = ($urandom_range(0, 99) < ((n / 250) % 2 == 0 ? 15 : 55));
      cycle("rnd", v, rand_code(), a);
      if (n == 900) do_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
